fxp32_round_prep: RTL and testbench

FXP32_ROUND_PREP -- requirements
Module: fxp32_round_prep

---
 rtl/fxp32_round_prep.sv | 95 +++++++++
 tb/tb_fxp32_round_prep.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp32_round_prep.sv
// Two-stage round/negate/saturate prep for a 32-bit carry incrementer.
// S1 holds the raw accumulator; S2 holds the incrementer operand and carry-in.
module fxp32_round_prep #(
  parameter int SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] in_acc,
  input  logic        in_neg,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_a,
  output logic        out_carry,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        clr_cnt,
  output logic [15:0] sat_cnt
);

  localparam int UW = 17 - SHIFT;

  logic        s1_valid;
  logic [47:0] s1_acc;
  logic        s1_neg;
  logic        s2_valid;

  logic          s2_free, s1_load, s2_load;
  logic [31:0]   trunc;
  logic          rbit, ov, sat, neg_tgt;
  logic [UW-1:0] upper;
  logic [31:0]   nxt_a;
  logic          nxt_c;

  // A stage may take new data when it is empty or its content is leaving.
  assign s2_free  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_free;

  assign trunc   = s1_acc[SHIFT+31:SHIFT];
  assign rbit    = s1_acc[SHIFT-1];
  assign upper   = s1_acc[47:SHIFT+31];
  assign ov      = !((&upper) || !(|upper));
  assign neg_tgt = s1_acc[47] ^ s1_neg;

  always_comb begin
    sat   = ov || (!s1_neg && trunc == 32'h7FFF_FFFF && rbit)
               || (s1_neg && trunc == 32'h8000_0000);
    nxt_a = s1_neg ? ~trunc : trunc;
    nxt_c = s1_neg ? 1'b1 : rbit;
    if (sat) begin
      nxt_a = neg_tgt ? 32'h8000_0000 : 32'h7FFF_FFFF;
      nxt_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_acc   <= '0;
      s1_neg   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_acc <= in_acc;
        s1_neg <= in_neg;
      end
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_free) s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_a     <= '0;
      out_carry <= 1'b0;
    end else begin
      if (s2_load) begin
        out_a     <= nxt_a;
        out_carry <= nxt_c;
      end
      if (s2_free) s2_valid <= s2_load;
    end
  end

  assign out_valid = s2_valid;

  // Saturation counter sticks at all-ones; clear wins over a same-cycle hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       sat_cnt <= '0;
    else if (clr_cnt)                                 sat_cnt <= '0;
    else if (s2_load && sat && sat_cnt != 16'hFFFF)   sat_cnt <= sat_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fxp32_round_prep.sv
// Directed bench for fxp32_round_prep (SHIFT=8): rounding, negation,
// saturation, backpressure, counter clear and asynchronous reset.
module tb_fxp32_round_prep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] in_acc;
  logic        in_neg;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a;
  logic        out_carry;
  logic        out_valid;
  logic        out_ready;
  logic        clr_cnt;
  logic [15:0] sat_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fxp32_round_prep #(.SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_acc(in_acc), .in_neg(in_neg),
    .in_valid(in_valid), .in_ready(in_ready), .out_a(out_a),
    .out_carry(out_carry), .out_valid(out_valid), .out_ready(out_ready),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // Drive one sample with out_ready=1, capture out_valid one cycle later
  // (must still be low) and the result two cycles later.
  task automatic one(input logic [47:0] acc, input logic neg,
                     output logic early_v, output logic v,
                     output logic [31:0] a, output logic c);
    @(negedge clk);
    in_acc = acc; in_neg = neg; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; early_v = out_valid;
    @(negedge clk);
    v = out_valid; a = out_a; c = out_carry;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_acc = '0; in_neg = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    rst_n = 1'b0;
    #2;
    n_chk++;
    if (out_valid !== 1'b0 || out_a !== 32'h0 || out_carry !== 1'b0 ||
        sat_cnt !== 16'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: ov=%b a=%h c=%b cnt=%h ir=%b, want 0 0 0 0 1",
               out_valid, out_a, out_carry, sat_cnt, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round();
    logic ev, v, c; logic [31:0] a;
    one(48'h0000_0000_0180, 1'b0, ev, v, a, c);
    n_chk++;
    if (ev !== 1'b0 || v !== 1'b1 || a !== 32'h1 || c !== 1'b1 || sat_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL round_up: ev=%b v=%b a=%h c=%b cnt=%0d, want 0 1 00000001 1 0",
               ev, v, a, c, sat_cnt);
    end
    one(48'hFFFF_FFFF_FE80, 1'b0, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'hFFFF_FFFE || c !== 1'b1 || sat_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL round_neg_val: v=%b a=%h c=%b cnt=%0d, want 1 fffffffe 1 0", v, a, c, sat_cnt);
    end
    one(48'h007F_FFFF_FF80, 1'b0, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'h7FFF_FFFF || c !== 1'b0 || sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL round_sat: v=%b a=%h c=%b cnt=%0d, want 1 7fffffff 0 1", v, a, c, sat_cnt);
    end
    one(48'hFF80_0000_0000, 1'b0, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'h8000_0000 || c !== 1'b0 || sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL min_no_sat: v=%b a=%h c=%b cnt=%0d, want 1 80000000 0 1", v, a, c, sat_cnt);
    end
  endtask

  task automatic test_negate();
    logic ev, v, c; logic [31:0] a;
    one(48'h0000_0000_0500, 1'b1, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'hFFFF_FFFA || c !== 1'b1 || sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL neg_pos: v=%b a=%h c=%b cnt=%0d, want 1 fffffffa 1 1", v, a, c, sat_cnt);
    end
    one(48'hFFFF_FFFF_FBFF, 1'b1, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'h0000_0004 || c !== 1'b1 || sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL neg_negval: v=%b a=%h c=%b cnt=%0d, want 1 00000004 1 1", v, a, c, sat_cnt);
    end
    one(48'hFF80_0000_0000, 1'b1, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'h7FFF_FFFF || c !== 1'b0 || sat_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL neg_min_sat: v=%b a=%h c=%b cnt=%0d, want 1 7fffffff 0 2", v, a, c, sat_cnt);
    end
  endtask

  task automatic test_overflow();
    logic ev, v, c; logic [31:0] a;
    one(48'h0080_0000_0000, 1'b0, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'h7FFF_FFFF || c !== 1'b0 || sat_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL ov_pos: v=%b a=%h c=%b cnt=%0d, want 1 7fffffff 0 3", v, a, c, sat_cnt);
    end
    one(48'hFF00_0000_0000, 1'b0, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'h8000_0000 || c !== 1'b0 || sat_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL ov_neg: v=%b a=%h c=%b cnt=%0d, want 1 80000000 0 4", v, a, c, sat_cnt);
    end
    one(48'hFF00_0000_0000, 1'b1, ev, v, a, c);
    n_chk++;
    if (v !== 1'b1 || a !== 32'h7FFF_FFFF || c !== 1'b0 || sat_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL ov_neg_inv: v=%b a=%h c=%b cnt=%0d, want 1 7fffffff 0 5", v, a, c, sat_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] acc [4];
    int idx = 0, got = 0, gap = 0;
    logic take;
    acc[0] = 48'h100; acc[1] = 48'h200; acc[2] = 48'h300; acc[3] = 48'h400;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_a !== 32'h1 || out_carry !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_hold c%0d: v=%b a=%h c=%b, want 1 00000001 0",
                   cyc, out_valid, out_a, out_carry);
        end
      end
      if (cyc == 5) begin
        n_chk++;
        if (idx != 2 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_stall: accepted=%0d in_ready=%b, want 2 0", idx, in_ready);
        end
      end
      out_ready = (cyc >= 5);
      if (out_valid && out_ready) begin
        n_chk++;
        if (got > 3 || out_a !== 32'(got + 1) || out_carry !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_order #%0d: a=%h c=%b, want %h 0", got, out_a, out_carry, got + 1);
        end
        got++;
      end else if (got > 0 && got < 4) gap++;
      in_valid = (idx < 4);
      if (idx < 4) begin in_acc = acc[idx]; in_neg = 1'b0; end
      #1;
      take = in_valid && in_ready;
      @(posedge clk);
      if (take) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++;
    if (got != 4 || gap != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got=%0d gaps=%0d, want 4 0", got, gap);
    end
  endtask

  task automatic test_reset_mid();
    logic ev, v, c; logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) one(48'h0080_0000_0000, 1'b0, ev, v, a, c);
    @(negedge clk);
    out_ready = 1'b0; in_acc = 48'h500; in_neg = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || sat_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL pre_reset: v=%b cnt=%0d, want 1 3", out_valid, sat_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || sat_cnt !== 16'd0 || out_a !== 32'h0 || out_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b cnt=%0d a=%h c=%b, want 0 0 0 0",
               out_valid, sat_cnt, out_a, out_carry);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: v=%b, want 0", out_valid);
    end
  endtask

  task automatic test_clr_cnt();
    logic ev, v, c; logic [31:0] a;
    one(48'h0080_0000_0000, 1'b0, ev, v, a, c);
    n_chk++;
    if (sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_setup: cnt=%0d, want 1", sat_cnt);
    end
    clr_cnt = 1'b1;
    one(48'hFF00_0000_0000, 1'b0, ev, v, a, c);
    clr_cnt = 1'b0;
    n_chk++;
    if (sat_cnt !== 16'd0 || v !== 1'b1 || a !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL clr_prio: cnt=%0d v=%b a=%h, want 0 1 80000000", sat_cnt, v, a);
    end
    one(48'hFF00_0000_0000, 1'b0, ev, v, a, c);
    n_chk++;
    if (sat_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_resume: cnt=%0d, want 1", sat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_round();
    test_negate();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_clr_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
